// File: rtl/seq_pkg.sv
// ------------------------------------------------------------------------
// seq_pkg : shared command format, func codes and sequencer states. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package seq_pkg;

  localparam int CMD_W    = 23;
  localparam int FUNC_MSB = 22;
  localparam int FUNC_LSB = 19;
  localparam int RX_MSB   = 18;
  localparam int RX_LSB   = 16;
  localparam int RY_MSB   = 15;
  localparam int RY_LSB   = 13;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [3:0] FUNC_HALT = 4'b0000;
  localparam logic [3:0] FUNC_LOAD = 4'b1000;
  localparam logic [3:0] FUNC_MOVE = 4'b1001;
  localparam logic [3:0] FUNC_ADD  = 4'b1010;
  localparam logic [3:0] FUNC_XOR  = 4'b1101;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SEP_ACK  = 3'd2,
    ST_SEP_DONE = 3'd3,
    ST_ISSUE    = 3'd4,
    ST_WAIT     = 3'd5,
    ST_HALT     = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

  function automatic logic [3:0] cmd_func(input logic [CMD_W-1:0] cmd);
    return cmd[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_prog_ram.sv
// ------------------------------------------------------------------------
// seq_prog_ram : program store, synchronous write, combinational read. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module seq_prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 23
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset: the program survives a sequencer reset.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/command_sequencer.sv
// ------------------------------------------------------------------------
// command_sequencer : runs the program store into the control FSM. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module command_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [CMD_W-1:0]  prog_data,
  input  logic              start,
  input  logic              done,
  output logic [CMD_W-1:0]  command,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t             r_state, w_state_nx;
  logic [CMD_W-1:0]   r_cmd, w_cmd_nx;
  logic [CMD_W-1:0]   r_instr, w_instr_nx;
  logic [ADDR_W-1:0]  r_pc, w_pc_nx;
  logic [3:0]         r_last_func, w_last_func_nx;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nx;

  logic               w_prog_ok;
  logic               w_waiting;
  logic [CMD_W-1:0]   w_rdata;

  assign w_prog_ok = (r_state == ST_IDLE) || (r_state == ST_HALT) || (r_state == ST_ERROR);
  assign w_waiting = (r_state == ST_SEP_ACK) || (r_state == ST_SEP_DONE) ||
                     (r_state == ST_ISSUE)   || (r_state == ST_WAIT);

  seq_prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CMD_W)
  ) u_ram (
    .clk   (clk),
    .we    (prog_we && w_prog_ok),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (r_pc),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_last_func <= FUNC_HALT;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cmd       <= w_cmd_nx;
      r_instr     <= w_instr_nx;
      r_pc        <= w_pc_nx;
      r_last_func <= w_last_func_nx;
      r_tmo       <= w_tmo_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cmd_nx       = r_cmd;
    w_instr_nx     = r_instr;
    w_pc_nx        = r_pc;
    w_last_func_nx = r_last_func;
    w_tmo_nx       = r_tmo;

    case (r_state)
      ST_IDLE: begin
        if (start && done) begin
          w_state_nx = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_instr_nx = w_rdata;
        if (cmd_func(w_rdata) == FUNC_HALT) begin
          w_state_nx = ST_HALT;
        end else if (cmd_func(w_rdata) == r_last_func) begin
          // Same func twice would look like no change to the control FSM.
          w_state_nx = ST_SEP_ACK;
          w_cmd_nx   = '0;
        end else begin
          w_state_nx = ST_ISSUE;
          w_cmd_nx   = w_rdata;
        end
      end
      ST_SEP_ACK: begin
        if (!done) begin
          w_state_nx = ST_SEP_DONE;
        end
      end
      ST_SEP_DONE: begin
        if (done) begin
          w_state_nx     = ST_ISSUE;
          w_cmd_nx       = r_instr;
          w_last_func_nx = FUNC_HALT;
        end
      end
      ST_ISSUE: begin
        if (!done) begin
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done) begin
          w_last_func_nx = cmd_func(r_instr);
          if (r_pc == {ADDR_W{1'b1}}) begin
            w_state_nx = ST_HALT;
          end else begin
            w_state_nx = ST_FETCH;
            w_pc_nx    = r_pc + ADDR_W'(1);
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          w_state_nx = ST_FETCH;
          w_pc_nx    = '0;
        end
      end
      ST_ERROR: begin
        if (start) begin
          w_state_nx     = ST_FETCH;
          w_pc_nx        = '0;
          w_last_func_nx = cmd_func(r_cmd);
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase

    // Any state change restarts the watchdog; staying put in a wait state ages it.
    if (w_state_nx != r_state) begin
      w_tmo_nx = '0;
    end else if (w_waiting) begin
      if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
        w_state_nx = ST_ERROR;
        w_tmo_nx   = '0;
      end else begin
        w_tmo_nx = r_tmo + TMO_W'(1);
      end
    end
  end

  assign command = r_cmd;
  assign pc      = r_pc;
  assign busy    = !w_prog_ok;
  assign halted  = (r_state == ST_HALT);
  assign error   = (r_state == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_command_sequencer.sv
// ------------------------------------------------------------------------
// tb_command_sequencer : scoreboard bench with a control-FSM done model. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_command_sequencer;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [22:0]       prog_data = '0;
  logic              start = 1'b0;
  logic              done;
  logic [22:0]       command;
  logic              busy;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              error;

  int checks = 0;
  int errors = 0;
  logic [22:0] exp_q[$];

  command_sequencer #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .done      (done),
    .command   (command),
    .busy      (busy),
    .pc        (pc),
    .halted    (halted),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Control FSM model: ack one cycle after a func change, complete 1 or 3 cycles later
  logic       m_done = 1'b1;
  logic [3:0] m_prev = 4'b0000;
  logic [1:0] m_cnt  = 2'd0;
  logic       stuck  = 1'b0;
  logic       hold_low = 1'b0;

  assign done = m_done && !hold_low;

  always @(posedge clk) begin
    if (reset) begin
      m_done <= 1'b1;
      m_prev <= 4'b0000;
      m_cnt  <= 2'd0;
    end else if (command[22:19] != m_prev) begin
      m_prev <= command[22:19];
      if (!stuck) begin
        m_done <= 1'b0;
        m_cnt  <= (command[22:19] == 4'b1010 || command[22:19] == 4'b1101) ? 2'd3 : 2'd1;
      end
    end else if (!m_done && m_cnt != 2'd0) begin
      if (m_cnt == 2'd1) m_done <= 1'b1;
      m_cnt <= m_cnt - 2'd1;
    end
  end

  function automatic logic [22:0] mk(input logic [3:0] f, input logic [2:0] rx, input logic [15:0] d);
    return {f, rx, d};
  endfunction

  function automatic logic [22:0] t5_val(input int i);
    return mk((i % 2 == 1) ? 4'b1001 : 4'b1000, 3'(i), 16'(i * 16 + 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issue (separator or instruction) changes command while busy
  logic [22:0] mon_prev = '0;
  logic        mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && busy && command !== mon_prev) begin
      if (exp_q.size() == 0) begin
        check("cmd_unexpected", {9'd0, command}, 32'hFFFF_FFFF);
      end else begin
        check("cmd_seq", {9'd0, command}, {9'd0, exp_q.pop_front()});
      end
    end
    mon_prev = command;
  end

  task automatic write_prog(input logic [ADDR_W-1:0] a, input logic [22:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts rising edges until halted (or error) is seen, bounded.
  task automatic wait_for(input bit want_err, output int n);
    n = 0;
    while (!(want_err ? error : halted) && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 300) check(want_err ? "wait_error" : "wait_halt", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_command", {9'd0, command}, 32'd0);
    check("rst_pc", {28'd0, pc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    mon_en = 1'b1;

    // T1: load, load (separator), add, halt
    write_prog(4'd0, mk(4'b1000, 3'd0, 16'h0005));
    write_prog(4'd1, mk(4'b1000, 3'd1, 16'h0003));
    write_prog(4'd2, mk(4'b1010, 3'd0, 16'h2000));
    write_prog(4'd3, 23'd0);
    exp_q.push_back(23'h400005);
    exp_q.push_back(23'h000000);
    exp_q.push_back(23'h410003);
    exp_q.push_back(23'h502000);
    pulse_start();
    wait_for(1'b0, n);
    check("t1_cycles", n, 32'd18);
    check("t1_halted", {31'd0, halted}, 32'd1);
    check("t1_pc", {28'd0, pc}, 32'd3);
    check("t1_busy", {31'd0, busy}, 32'd0);

    // T2: move then xor, no separator; written while halted
    write_prog(4'd0, mk(4'b1001, 3'd2, 16'h6000));
    write_prog(4'd1, mk(4'b1101, 3'd1, 16'h0042));
    write_prog(4'd2, 23'd0);
    exp_q.push_back(23'h4A6000);
    exp_q.push_back(23'h690042);
    pulse_start();
    wait_for(1'b0, n);
    check("t2_cycles", n, 32'd11);
    check("t2_pc", {28'd0, pc}, 32'd2);

    // T3: control FSM never acks -> ERROR, then restart from ERROR
    write_prog(4'd0, mk(4'b1000, 3'd3, 16'h0077));
    stuck = 1'b1;
    exp_q.push_back(23'h430077);
    pulse_start();
    wait_for(1'b1, n);
    check("t3_err_cycles", n, 32'd1 + TIMEOUT);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    stuck = 1'b0;
    exp_q.push_back(23'h000000);
    exp_q.push_back(23'h430077);
    exp_q.push_back(23'h690042);
    pulse_start();
    wait_for(1'b0, n);
    check("t3_restart_pc", {28'd0, pc}, 32'd2);
    check("t3_restart_err", {31'd0, error}, 32'd0);

    // T4: reset during WAIT of an add, then protected-write and rerun
    write_prog(4'd0, mk(4'b1010, 3'd2, 16'h1234));
    write_prog(4'd1, mk(4'b1000, 3'd5, 16'h00AA));
    write_prog(4'd2, mk(4'b1001, 3'd6, 16'h00BB));
    write_prog(4'd3, 23'd0);
    exp_q.push_back(23'h521234);
    pulse_start();
    repeat (3) @(posedge clk);
    #1 check("t4_busy_wait", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("t4_rst_command", {9'd0, command}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_pc", {28'd0, pc}, 32'd0);
    hold_low = 1'b1;
    pulse_start();
    @(posedge clk);
    #1 check("t4_start_done0", {31'd0, busy}, 32'd0);
    hold_low = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.push_back(23'h521234);
    exp_q.push_back(23'h4500AA);
    exp_q.push_back(23'h4E00BB);
    pulse_start();
    repeat (2) @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = mk(4'b1101, 3'd7, 16'hDEAD);
    @(negedge clk);
    prog_we = 1'b0;
    wait_for(1'b0, n);
    check("t4_pc", {28'd0, pc}, 32'd3);

    // T5: 16 instructions with no HALT; [0] written in the same cycle as start
    for (int i = 1; i < 16; i++) write_prog(4'(i), t5_val(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(t5_val(i));
    @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = t5_val(0);
    @(posedge clk);
    #1 start = 1'b0;
    prog_we = 1'b0;
    wait_for(1'b0, n);
    check("t5_cycles", n, 32'd64);
    check("t5_pc", {28'd0, pc}, 32'd15);
    repeat (4) @(posedge clk);
    #1 check("t5_no_wrap", {28'd0, pc}, 32'd15);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
